mult_div: RTL and testbench

Multi-cycle multiply/divide unit of the MIPS pipeline (execute stage), owning the HI/LO register pair. Accepts one operation per `Start` pulse, holds `Busy` for a fixed latency, then commits the 64-bit result to HI/LO. The hazard unit stalls any HI/LO-dependent instruction while `Busy` or `Start` is high.

---
 rtl/mult_div_pkg.sv | 19 +
 rtl/mult_div.sv | 111 +++++++++++
 tb/tb_mult_div.sv | 112 +++++++++++
 3 files changed

// File: rtl/mult_div_pkg.sv
// Shared ALUOp encodings and default latencies for the HI/LO multiply/divide unit.
package mult_div_pkg;

  localparam logic [3:0] MD_MULT  = 4'b1100;
  localparam logic [3:0] MD_MULTU = 4'b1101;
  localparam logic [3:0] MD_DIV   = 4'b1110;
  localparam logic [3:0] MD_DIVU  = 4'b1111;
  localparam logic [3:0] MD_MTHI  = 4'b1010;
  localparam logic [3:0] MD_MTLO  = 4'b1011;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

endpackage

// File: rtl/mult_div.sv
// Multi-cycle multiply/divide unit owning HI/LO; result computed at Start, committed after a fixed latency.
// Optional mthi/mtlo support is enabled by defining MULTDIV_MTHILO_EN.
//
// state   | meaning
// ST_IDLE | no operation in flight, Start accepted
// ST_RUN  | cnt counting down to commit of the captured result
module mult_div
  import mult_div_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [3:0]  ALUOp,
  input  logic [31:0] D1,
  input  logic [31:0] D2,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  md_state_e         state;
  logic [CNT_W-1:0]  cnt;
  logic [31:0]       tmp_hi;
  logic [31:0]       tmp_lo;
  logic              tmp_wr;

  logic [63:0] prod;
  logic        div_signed;
  logic [31:0] dvd, dvs, dvs_safe, q_mag, r_mag, quo, rem;

  // Signed divide works on magnitudes so 0x8000_0000 / -1 falls out as 0x8000_0000 rem 0.
  always_comb begin
    prod       = '0;
    div_signed = (ALUOp == MD_DIV);
    if (ALUOp == MD_MULT)
      prod = $signed({{32{D1[31]}}, D1}) * $signed({{32{D2[31]}}, D2});
    else
      prod = {32'b0, D1} * {32'b0, D2};
    dvd      = (div_signed && D1[31]) ? -D1 : D1;
    dvs      = (div_signed && D2[31]) ? -D2 : D2;
    dvs_safe = (dvs == 32'b0) ? 32'd1 : dvs;
    q_mag    = dvd / dvs_safe;
    r_mag    = dvd % dvs_safe;
    quo      = (div_signed && (D1[31] ^ D2[31])) ? -q_mag : q_mag;
    rem      = (div_signed && D1[31]) ? -r_mag : r_mag;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      Busy   <= 1'b0;
      HI     <= '0;
      LO     <= '0;
      tmp_hi <= '0;
      tmp_lo <= '0;
      tmp_wr <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (Start) begin
            case (ALUOp)
              MD_MULT, MD_MULTU: begin
                state  <= ST_RUN;
                cnt    <= CNT_W'(MULT_CYCLES);
                Busy   <= 1'b1;
                tmp_hi <= prod[63:32];
                tmp_lo <= prod[31:0];
                tmp_wr <= 1'b1;
              end
              MD_DIV, MD_DIVU: begin
                state  <= ST_RUN;
                cnt    <= CNT_W'(DIV_CYCLES);
                Busy   <= 1'b1;
                tmp_hi <= rem;
                tmp_lo <= quo;
                tmp_wr <= (D2 != 32'b0);
              end
`ifdef MULTDIV_MTHILO_EN
              MD_MTHI: HI <= D1;
              MD_MTLO: LO <= D1;
`endif
              default: ;
            endcase
          end
        end
        ST_RUN: begin
          if (cnt == CNT_W'(1)) begin
            state <= ST_IDLE;
            cnt   <= '0;
            Busy  <= 1'b0;
            if (tmp_wr) begin
              HI <= tmp_hi;
              LO <= tmp_lo;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div.sv
// Directed bench for mult_div; mthi/mtlo expectations follow MULTDIV_MTHILO_EN.
module tb_mult_div;
  import mult_div_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        Start = 1'b0;
  logic [3:0]  ALUOp = 4'b0;
  logic [31:0] D1 = '0;
  logic [31:0] D2 = '0;
  logic        Busy;
  logic [31:0] HI, LO;

  int n_chk  = 0;
  int n_fail = 0;

  mult_div #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .Start (Start),
    .ALUOp (ALUOp),
    .D1    (D1),
    .D2    (D2),
    .Busy  (Busy),
    .HI    (HI),
    .LO    (LO)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Launch one op, scramble inputs afterwards, count Busy cycles, then check HI/LO.
  // inj >= 0 pulses a mult Start on that busy cycle, which must be ignored.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int n, input logic [31:0] ehi,
                        input logic [31:0] elo, input int inj);
    int cyc;
    @(negedge clk);
    Start = 1'b1; ALUOp = op; D1 = a; D2 = b;
    @(posedge clk); #1;
    Start = 1'b0; ALUOp = 4'b0; D1 = $urandom; D2 = $urandom;
    cyc = 0;
    while (Busy && cyc < 100) begin
      cyc++;
      Start = (cyc == inj);
      ALUOp = MD_MULT; D1 = 32'd3; D2 = 32'd3;
      @(posedge clk); #1;
    end
    Start = 1'b0;
    chk({tag, "_busy"}, 32'(cyc), 32'(n));
    chk({tag, "_hi"}, HI, ehi);
    chk({tag, "_lo"}, LO, elo);
  endtask

  initial begin
    #12 reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_busy", {31'b0, Busy}, 32'd0);
    chk("rst_hi", HI, 32'h0);
    chk("rst_lo", LO, 32'h0);

    run_op("divu",  MD_DIVU,  32'hFFFF_FFFF, 32'h2, 10, 32'h1, 32'h7FFF_FFFF, -1);
    run_op("mult",  MD_MULT,  32'hFFFF_FFFF, 32'h2, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFE, -1);
    run_op("multu", MD_MULTU, 32'hFFFF_FFFF, 32'h2, 5, 32'h1, 32'hFFFF_FFFE, -1);
    run_op("mult2", MD_MULT,  32'h0001_0000, 32'h0001_0000, 5, 32'h1, 32'h0, -1);
    run_op("divn",  MD_DIV,   32'hFFFF_FFF9, 32'h2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, -1);
    run_op("div0",  MD_DIV,   32'h1234_5678, 32'h0, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, -1);
    run_op("divu0", MD_DIVU,  32'h1, 32'h0, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, -1);
    run_op("divnd", MD_DIV,   32'h7, 32'hFFFF_FFFE, 10, 32'h1, 32'hFFFF_FFFD, -1);
    run_op("divov", MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0, 32'h8000_0000, -1);
    run_op("nop",   4'b0000,  32'hDEAD_BEEF, 32'h1, 0, 32'h0, 32'h8000_0000, -1);
    run_op("ign",   MD_DIVU,  32'd100, 32'd7, 10, 32'd2, 32'd14, 3);

`ifdef MULTDIV_MTHILO_EN
    run_op("mthi", MD_MTHI, 32'h1234, 32'h0, 0, 32'h1234, 32'd14, -1);
    run_op("mtlo", MD_MTLO, 32'h5678, 32'h0, 0, 32'h1234, 32'h5678, -1);
`else
    run_op("mthi", MD_MTHI, 32'h1234, 32'h0, 0, 32'd2, 32'd14, -1);
    run_op("mtlo", MD_MTLO, 32'h5678, 32'h0, 0, 32'd2, 32'd14, -1);
`endif

    // Reset mid-operation discards the in-flight result.
    @(negedge clk);
    Start = 1'b1; ALUOp = MD_MULTU; D1 = 32'd9; D2 = 32'd9;
    @(posedge clk); #1;
    Start = 1'b0;
    chk("mid_busy", {31'b0, Busy}, 32'd1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #2;
    chk("rstmid_busy", {31'b0, Busy}, 32'd0);
    chk("rstmid_hi", HI, 32'h0);
    chk("rstmid_lo", LO, 32'h0);
    @(negedge clk) reset = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("rstmid_lo_after", LO, 32'h0);

    run_op("post", MD_MULTU, 32'd9, 32'd9, 5, 32'h0, 32'd81, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
